tt_um_down_timer: RTL and testbench
===================================

Name: tt_um_down_timer

Overview:
- Programmable countdown timer: loads a start value, decrements once per clock while running, and emits a one-cycle expire pulse at terminal count.
- Supports one-shot and periodic (auto-reload) modes, plus pause/resume and a wrapping expiration counter.
- Complements the free-running up counter used elsewhere in the design; serves as the design's interval/timeout generator.

Parameters:
- BW, 8, width of the count, reload and expiration-counter registers.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_ni  input  1  asynchronous, active-low reset.
- load_valid_i  input  1  load request.
- load_ready_o  output  1  load can be accepted; high when state != RUN.
- load_val_i  input  BW  value to load.
- mode_i  input  1  0 = one-shot, 1 = periodic; sampled at start.
- start_i  input  1  start or resume request.
- stop_i  input  1  pause request.
- count_o  output  BW  current count (registered).
- busy_o  output  1  high in RUN.
- expire_o  output  1  registered one-cycle pulse at terminal count.
- expire_cnt_o  output  BW  number of expirations since the last load, wrapping modulo 2^BW.

Behaviour:
- Reset (asynchronous assert, any state, including mid-run):
  - state = IDLE; count_q = reload_q = expire_cnt = 0; mode_q = 0.
  - expire_o = 0, busy_o = 0, load_ready_o = 1.
  - Outputs take these values immediately on assert. Release is synchronous to clk_i.
- States are IDLE, RUN, PAUSE and DONE. busy_o = (state == RUN). load_ready_o = (state != RUN), combinational from state.
- Load handshake: a transfer occurs on an edge where load_valid_i && load_ready_o.
  - reload_q and count_q take load_val_i; expire_cnt clears to 0; next state = IDLE.
  - Load has priority over start_i in the same cycle.
  - During RUN a load is not accepted and load_val_i is ignored; the requester must hold load_valid_i.
- Start:
  - IDLE with start_i and count_q != 0: latch mode_q <= mode_i, go to RUN. No decrement on the start edge; the first decrement happens on the next edge.
  - IDLE with start_i and count_q == 0: ignored; stay in IDLE.
  - PAUSE with start_i: go to RUN, count held, mode_q unchanged.
  - DONE with start_i and reload_q != 0: count_q <= reload_q, latch mode_q, go to RUN. If reload_q == 0, ignored.
- Run, each edge with stop_i low:
  - count_q > 1: count_q decrements by 1.
  - count_q == 1, one-shot: count_q <= 0, expire_o <= 1, expire_cnt++, go to DONE.
  - count_q == 1, periodic: count_q <= reload_q, expire_o <= 1, expire_cnt++, stay in RUN.
  - Resulting period: N cycles for load value N. Periodic count_o never shows 0.
- Stop: stop_i in RUN goes to PAUSE on that edge with count_q held (no decrement). stop_i wins over start_i and over terminal count in the same cycle. stop_i outside RUN is ignored.
- expire_o is high for exactly one cycle per expiration and is low in every other cycle.
- Arithmetic:
  - All arithmetic is unsigned BW-bit.
  - expire_cnt wraps from 2^BW-1 to 0 with no saturation.
  - reload of 2^BW-1 is legal.
- DONE holds count_o = 0 until a load or start.

Decomposition:
- Shared header tt_timer_defs.vh contains:
  - state encodings (IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, DONE = 2'd3);
  - mode constants (MODE_ONESHOT = 1'b0, MODE_PERIODIC = 1'b1).
- One sub-module, tt_um_event_counter: BW-bit up counter with an increment enable and a synchronous clear (clear has priority). It implements expire_cnt_o.
- The FSM and the count/reload datapath stay in the top module.

Test Plan:
- Reset/idle: assert rst_ni low mid-RUN with count 5 -> count_o = 0, busy_o = 0, expire_o = 0, load_ready_o = 1 immediately, before the next clock edge.
- One-shot: load 3, start with mode 0 -> count_o 3,3,2,1,0 on successive cycles, expire_o high only in the cycle count_o first reads 0, then DONE; expire_cnt_o = 1.
- Periodic: load 3, start with mode 1, run 10 cycles -> count_o 3,2,1,3,2,1,3,... with expire_o every 3rd cycle, coincident with count_o returning to 3; expire_cnt_o = 3.
- Pause/resume: load 5, start, assert stop_i when count_o = 3, hold for 4 cycles, then start_i -> count_o stays 3 during PAUSE, resumes 2,1,0; busy_o low while paused. Also assert stop_i and start_i together in RUN -> PAUSE.
- Load handshake:
  - load_valid_i with 9 during RUN -> load_ready_o = 0 and count_o unaffected.
  - Load in PAUSE -> count_o = 9, expire_cnt_o = 0, state IDLE.
  - Start with count 0 -> stays idle, busy_o = 0.
- Wrap: BW = 4, periodic reload 1, run 17 cycles -> expire_o high every cycle, count_o stays 1, expire_cnt_o wraps 15 -> 0 and ends at 1.

Source files
------------

// File: rtl/tt_um_down_timer_pkg.sv
// Shared constants for the down timer: FSM state encodings and run modes.
package tt_um_down_timer_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/tt_um_down_timer_if.sv
// Control and status bundle of the down timer. The master drives the load
// handshake and start/stop/mode controls; the slave (the timer) drives status.
interface tt_um_down_timer_if #(parameter int BW = 8);

  logic          load_valid_i;
  logic          load_ready_o;
  logic [BW-1:0] load_val_i;
  logic          mode_i;
  logic          start_i;
  logic          stop_i;
  logic [BW-1:0] count_o;
  logic          busy_o;
  logic          expire_o;
  logic [BW-1:0] expire_cnt_o;

  modport master (
    output load_valid_i, load_val_i, mode_i, start_i, stop_i,
    input  load_ready_o, count_o, busy_o, expire_o, expire_cnt_o
  );

  modport slave (
    input  load_valid_i, load_val_i, mode_i, start_i, stop_i,
    output load_ready_o, count_o, busy_o, expire_o, expire_cnt_o
  );

endinterface

// File: rtl/tt_um_down_timer_event_counter.sv
// BW-bit wrapping up counter with increment enable and synchronous clear.
// Clear wins over increment so a load always leaves the counter at zero.
module tt_um_event_counter #(
  parameter int BW = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr,
  input  logic          inc,
  output logic [BW-1:0] value
);

  logic [BW-1:0] cnt_q;

  // Clear has priority; increment wraps modulo 2^BW without saturating.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc) begin
      cnt_q <= cnt_q + BW'(1);
    end
  end

  assign value = cnt_q;

endmodule

// File: rtl/tt_um_down_timer.sv
// Programmable countdown timer with one-shot / periodic modes, pause/resume
// and a wrapping expiration counter. FSM and count/reload datapath live here.
module tt_um_down_timer
  import tt_um_down_timer_pkg::*;
#(
  parameter int BW = 8
) (
  input logic             clk_i,
  input logic             rst_ni,
  tt_um_down_timer_if.slave bus
);

  localparam logic [BW-1:0] ONE = BW'(1);

  logic [1:0]    state_q, state_d;
  logic [BW-1:0] count_q, count_d;
  logic [BW-1:0] reload_q, reload_d;
  logic          mode_q, mode_d;
  logic          expire_q, expire_d;
  logic          load_ready;
  logic          load_fire;
  logic          cnt_clr;
  logic          cnt_inc;

  assign load_ready = (state_q != ST_RUN);
  assign load_fire  = bus.load_valid_i && load_ready;

  // Next-state logic: a load beats everything, otherwise the current state decides.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    mode_d   = mode_q;
    expire_d = 1'b0;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    if (load_fire) begin
      count_d  = bus.load_val_i;
      reload_d = bus.load_val_i;
      cnt_clr  = 1'b1;
      state_d  = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start_i && (count_q != '0)) begin
            mode_d  = bus.mode_i;
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (bus.stop_i) begin
            state_d = ST_PAUSE;
          end else if (count_q > ONE) begin
            count_d = count_q - ONE;
          end else if (count_q == ONE) begin
            expire_d = 1'b1;
            cnt_inc  = 1'b1;
            if (mode_q == MODE_PERIODIC) begin
              count_d = reload_q;
            end else begin
              count_d = '0;
              state_d = ST_DONE;
            end
          end
        end
        ST_PAUSE: begin
          if (bus.start_i) begin
            state_d = ST_RUN;
          end
        end
        ST_DONE: begin
          if (bus.start_i && (reload_q != '0)) begin
            count_d = reload_q;
            mode_d  = bus.mode_i;
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and datapath registers; reset forces an idle, empty timer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      reload_q <= '0;
      mode_q   <= MODE_ONESHOT;
      expire_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      mode_q   <= mode_d;
      expire_q <= expire_d;
    end
  end

  tt_um_event_counter #(.BW(BW)) u_expire_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr    (cnt_clr),
    .inc    (cnt_inc),
    .value  (bus.expire_cnt_o)
  );

  assign bus.load_ready_o = load_ready;
  assign bus.count_o      = count_q;
  assign bus.busy_o       = (state_q == ST_RUN);
  assign bus.expire_o     = expire_q;

endmodule

// File: tb/tb_tt_um_down_timer.sv
// Bench for tt_um_down_timer: directed vector table, reset and wrap sequences,
// then random stimulus against a behavioural timer model.
module tb_tt_um_down_timer;

  logic clk_i;
  logic rst_ni;

  tt_um_down_timer_if #(.BW(8)) bus ();
  tt_um_down_timer_if #(.BW(4)) bus4 ();

  tt_um_down_timer #(.BW(8)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus.slave)
  );

  tt_um_down_timer #(.BW(4)) dut4 (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus4.slave)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    bit         lv;
    logic [7:0] val;
    bit         mode;
    bit         start;
    bit         stop;
    logic [7:0] e_count;
    bit         e_busy;
    bit         e_expire;
    bit         e_ready;
    logic [7:0] e_cnt;
  } vec_t;

  vec_t tbl[$];

  // behavioural model: a timer is running, paused, finished or idle
  bit m_running, m_paused, m_done, m_periodic, m_expire;
  int m_count, m_reload, m_exp;

  function automatic vec_t mk(bit lv, int val, bit mode, bit start, bit stop,
                              int ec, bit eb, bit ee, bit er, int ecnt);
    vec_t v;
    v.lv = lv; v.val = val[7:0]; v.mode = mode; v.start = start; v.stop = stop;
    v.e_count = ec[7:0]; v.e_busy = eb; v.e_expire = ee; v.e_ready = er;
    v.e_cnt = ecnt[7:0];
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] actual,
                             input logic [7:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit lv, input logic [7:0] val, input bit mode,
                               input bit start, input bit stop);
    bus.load_valid_i = lv;
    bus.load_val_i   = val;
    bus.mode_i       = mode;
    bus.start_i      = start;
    bus.stop_i       = stop;
    @(posedge clk_i);
    #1;
  endtask

  task automatic model_reset();
    m_running = 0; m_paused = 0; m_done = 0; m_periodic = 0; m_expire = 0;
    m_count = 0; m_reload = 0; m_exp = 0;
  endtask

  task automatic model_step(input bit lv, input int val, input bit mode,
                            input bit start, input bit stop);
    m_expire = 0;
    if (lv && !m_running) begin
      m_count = val; m_reload = val; m_exp = 0;
      m_running = 0; m_paused = 0; m_done = 0;
    end else if (m_running) begin
      if (stop) begin
        m_running = 0; m_paused = 1;
      end else if (m_count == 1) begin
        m_expire = 1;
        m_exp = (m_exp + 1) % 256;
        if (m_periodic) m_count = m_reload;
        else begin
          m_count = 0; m_running = 0; m_done = 1;
        end
      end else begin
        m_count = m_count - 1;
      end
    end else if (m_paused) begin
      if (start) begin
        m_paused = 0; m_running = 1;
      end
    end else if (m_done) begin
      if (start && m_reload != 0) begin
        m_count = m_reload; m_periodic = mode; m_done = 0; m_running = 1;
      end
    end else if (start && m_count != 0) begin
      m_periodic = mode; m_running = 1;
    end
  endtask

  task automatic do_reset();
    bus.load_valid_i = 0; bus.load_val_i = '0; bus.mode_i = 0;
    bus.start_i = 0; bus.stop_i = 0;
    bus4.load_valid_i = 0; bus4.load_val_i = '0; bus4.mode_i = 0;
    bus4.start_i = 0; bus4.stop_i = 0;
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  initial begin
    do_reset();

    // reset state
    checkOutput("reset count", bus.count_o, 8'd0);
    checkOutput("reset busy", {7'd0, bus.busy_o}, 8'd0);
    checkOutput("reset expire", {7'd0, bus.expire_o}, 8'd0);
    checkOutput("reset ready", {7'd0, bus.load_ready_o}, 8'd1);
    checkOutput("reset expire_cnt", bus.expire_cnt_o, 8'd0);

    //          lv val md st sp  cnt busy exp rdy ecnt
    tbl.push_back(mk(1, 3, 0, 0, 0, 3, 0, 0, 1, 0));  // load 3
    tbl.push_back(mk(0, 0, 0, 1, 0, 3, 1, 0, 0, 0));  // start one-shot, no decrement
    tbl.push_back(mk(0, 0, 0, 0, 0, 2, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1));  // terminal count -> DONE
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1));  // DONE holds 0
    tbl.push_back(mk(0, 0, 1, 1, 0, 3, 1, 0, 0, 1));  // restart periodic from reload
    tbl.push_back(mk(0, 0, 0, 0, 0, 2, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 3, 1, 1, 0, 2));  // periodic reload
    tbl.push_back(mk(0, 0, 0, 0, 0, 2, 1, 0, 0, 2));
    tbl.push_back(mk(0, 0, 0, 0, 1, 2, 0, 0, 1, 2));  // pause
    tbl.push_back(mk(0, 0, 0, 0, 0, 2, 0, 0, 1, 2));
    tbl.push_back(mk(0, 0, 0, 1, 0, 2, 1, 0, 0, 2));  // resume
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 2));
    tbl.push_back(mk(0, 0, 0, 1, 1, 1, 0, 0, 1, 2));  // stop beats start and terminal
    tbl.push_back(mk(1, 9, 0, 0, 0, 9, 0, 0, 1, 0));  // load in PAUSE
    tbl.push_back(mk(0, 0, 0, 1, 0, 9, 1, 0, 0, 0));
    tbl.push_back(mk(1, 5, 0, 0, 0, 8, 1, 0, 0, 0));  // load ignored in RUN
    tbl.push_back(mk(1, 5, 0, 0, 1, 8, 0, 0, 1, 0));  // stop wins, load waits
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 1, 0));  // load 0 beats start
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 0));  // start with 0 ignored
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 1, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i].lv, tbl[i].val, tbl[i].mode, tbl[i].start, tbl[i].stop);
      checkOutput($sformatf("tbl%0d count", i), bus.count_o, tbl[i].e_count);
      checkOutput($sformatf("tbl%0d busy", i), {7'd0, bus.busy_o}, {7'd0, tbl[i].e_busy});
      checkOutput($sformatf("tbl%0d expire", i), {7'd0, bus.expire_o}, {7'd0, tbl[i].e_expire});
      checkOutput($sformatf("tbl%0d ready", i), {7'd0, bus.load_ready_o}, {7'd0, tbl[i].e_ready});
      checkOutput($sformatf("tbl%0d expire_cnt", i), bus.expire_cnt_o, tbl[i].e_cnt);
    end

    // asynchronous reset mid-run with count 5, checked before the next edge
    applyStimulus(1, 8'd5, 0, 0, 0);
    applyStimulus(0, 8'd0, 0, 1, 0);
    checkOutput("pre-reset count", bus.count_o, 8'd5);
    checkOutput("pre-reset busy", {7'd0, bus.busy_o}, 8'd1);
    bus.start_i = 0;
    #2;
    rst_ni = 1'b0;
    #1;
    checkOutput("async rst count", bus.count_o, 8'd0);
    checkOutput("async rst busy", {7'd0, bus.busy_o}, 8'd0);
    checkOutput("async rst expire", {7'd0, bus.expire_o}, 8'd0);
    checkOutput("async rst ready", {7'd0, bus.load_ready_o}, 8'd1);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;

    // BW=4 wrap: periodic reload 1 expires every cycle, counter wraps 15 -> 0
    bus4.load_valid_i = 1; bus4.load_val_i = 4'd1;
    @(posedge clk_i); #1;
    bus4.load_valid_i = 0; bus4.start_i = 1; bus4.mode_i = 1;
    @(posedge clk_i); #1;
    bus4.start_i = 0;
    checkOutput("wrap start count", {4'd0, bus4.count_o}, 8'd1);
    checkOutput("wrap start expire", {7'd0, bus4.expire_o}, 8'd0);
    for (int k = 1; k <= 17; k++) begin
      @(posedge clk_i); #1;
      checkOutput($sformatf("wrap%0d expire", k), {7'd0, bus4.expire_o}, 8'd1);
      checkOutput($sformatf("wrap%0d count", k), {4'd0, bus4.count_o}, 8'd1);
      checkOutput($sformatf("wrap%0d expire_cnt", k), {4'd0, bus4.expire_cnt_o}, 8'(k % 16));
    end

    // random stimulus against the model
    do_reset();
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      bit lv, md, st, sp;
      int val;
      lv  = ($urandom_range(0, 7) == 0);
      val = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 6));
      md  = 1'($urandom_range(0, 1));
      st  = ($urandom_range(0, 3) == 0);
      sp  = ($urandom_range(0, 11) == 0);
      applyStimulus(lv, val[7:0], md, st, sp);
      model_step(lv, val, md, st, sp);
      checkOutput($sformatf("rnd%0d count", n), bus.count_o, m_count[7:0]);
      checkOutput($sformatf("rnd%0d busy", n), {7'd0, bus.busy_o}, {7'd0, m_running});
      checkOutput($sformatf("rnd%0d expire", n), {7'd0, bus.expire_o}, {7'd0, m_expire});
      checkOutput($sformatf("rnd%0d ready", n), {7'd0, bus.load_ready_o}, {7'd0, !m_running});
      checkOutput($sformatf("rnd%0d expire_cnt", n), bus.expire_cnt_o, m_exp[7:0]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
